tx_arbiter: RTL and testbench

//  Round-robin arbiter that shares one UART transmitter (8N1 serializer, i_data/i_we/o_busy) among N byte sources.

---
 rtl/tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmitter among N byte sources.
// Supports a per-source message lock with an idle timeout, so a stalled source cannot hold the line.
module tx_arbiter #(
    parameter int N        = 4,
    parameter int LOCK_TMO = 23400,
    parameter int TMO_W    = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_valid,
    input  logic [8*N-1:0] i_data,
    input  logic [N-1:0]   i_last,
    output logic [N-1:0]   o_ready,
    output logic [7:0]     o_tx_data,
    output logic           o_tx_we,
    input  logic           i_tx_busy,
    output logic [N-1:0]   o_grant,
    output logic           o_active,
    output logic           o_lock_tmo
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ARB,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             lock_q, lock_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [N-1:0]     ready_q, ready_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic             we_q, we_d;
    logic             active_q, active_d;
    logic             lock_tmo_q, lock_tmo_d;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic             take;
    logic [IDX_W-1:0] take_idx;

    // Search starts one past the last served lane, so the last winner has lowest priority.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N);
            if (!pick_vld && i_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        tmo_d      = tmo_q;
        ready_d    = '0;
        grant_d    = grant_q;
        data_d     = data_q;
        we_d       = 1'b0;
        lock_tmo_d = 1'b0;
        take       = 1'b0;
        take_idx   = pick_idx;

        case (state_q)
            ARB: begin
                if (lock_q) begin
                    // While locked only the owner (held in ptr_q) is eligible.
                    if (i_valid[ptr_q]) begin
                        take     = 1'b1;
                        take_idx = ptr_q;
                    end else if (tmo_q == TMO_W'(LOCK_TMO - 1)) begin
                        lock_d     = 1'b0;
                        lock_tmo_d = 1'b1;
                        tmo_d      = '0;
                        grant_d    = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end else if (pick_vld) begin
                    take = 1'b1;
                end else begin
                    grant_d = '0;
                end

                if (take) begin
                    ready_d[take_idx] = 1'b1;
                    grant_d           = '0;
                    grant_d[take_idx] = 1'b1;
                    data_d            = i_data[{take_idx, 3'b000} +: 8];
                    ptr_d             = take_idx;
                    lock_d            = ~i_last[take_idx];
                    tmo_d             = '0;
                    state_d           = LOAD;
                end
            end
            // The accept pulse is visible during LOAD; the write strobe follows one cycle later.
            LOAD: begin
                we_d    = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!i_tx_busy) state_d = ARB;
            end
            default: state_d = ARB;
        endcase

        active_d = (state_d != ARB);
    end

    // NOTE: state registers use non-blocking assignments; the reset is synchronous to i_clk.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ARB;
            ptr_q      <= IDX_W'(N - 1);
            lock_q     <= 1'b0;
            tmo_q      <= '0;
            ready_q    <= '0;
            grant_q    <= '0;
            data_q     <= 8'h00;
            we_q       <= 1'b0;
            active_q   <= 1'b0;
            lock_tmo_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            tmo_q      <= tmo_d;
            ready_q    <= ready_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            we_q       <= we_d;
            active_q   <= active_d;
            lock_tmo_q <= lock_tmo_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_grant    = grant_q;
    assign o_tx_data  = data_q;
    assign o_tx_we    = we_q;
    assign o_active   = active_q;
    assign o_lock_tmo = lock_tmo_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: queued byte sources, a behavioural 8N1 transmitter,
// and hand-computed expectations for ordering, locking, timeout and busy timing.
module tb_tx_arbiter;
    localparam int N        = 4;
    localparam int LOCK_TMO = 23400;
    localparam int TMO_W    = 16;

    logic           clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_valid;
    logic [8*N-1:0] i_data;
    logic [N-1:0]   i_last;
    logic [N-1:0]   o_ready;
    logic [7:0]     o_tx_data;
    logic           o_tx_we;
    logic           tx_busy = 1'b0;
    logic [N-1:0]   o_grant;
    logic           o_active;
    logic           o_lock_tmo;

    always #5 clk = ~clk;

    tx_arbiter #(.N(N), .LOCK_TMO(LOCK_TMO), .TMO_W(TMO_W)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ready    (o_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_we    (o_tx_we),
        .i_tx_busy  (tx_busy),
        .o_grant    (o_grant),
        .o_active   (o_active),
        .o_lock_tmo (o_lock_tmo)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte sources: per-lane queues {last, data}; main pushes (tail), driver pops (head).
    logic [8:0] src_mem [N][32];
    int         src_head [N];
    int         src_tail [N];

    task automatic push(input int k, input logic [7:0] d, input logic last);
        src_mem[k][src_tail[k]] = {last, d};
        src_tail[k]++;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            src_head[k] = 0;
            src_tail[k] = 0;
        end
        i_valid = '0;
        i_data  = '0;
        i_last  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++)
                if (o_ready[k] && src_head[k] < src_tail[k]) src_head[k]++;
            #1;
            for (int k = 0; k < N; k++) begin
                i_valid[k] = (src_head[k] < src_tail[k]);
                i_data[8*k +: 8] = i_valid[k] ? src_mem[k][src_head[k]][7:0] : 8'h00;
                i_last[k]  = i_valid[k] ? src_mem[k][src_head[k]][8] : 1'b0;
            end
        end
    end

    // Behavioural transmitter: busy rises the cycle after the strobe, low again 10 bit-times later.
    int         bit_clks = 234;
    int         tx_left  = 0;
    int         tx_cnt   = 0;
    logic [9:0] tx_frame = 10'h3FF;
    logic       tx_serial;

    always @(posedge clk) begin
        if (tx_left == 0) begin
            if (o_tx_we) begin
                tx_busy  <= 1'b1;
                tx_left  <= 10 * bit_clks;
                tx_frame <= {1'b1, o_tx_data, 1'b0};
                tx_cnt   <= 0;
            end
        end else begin
            tx_cnt  <= tx_cnt + 1;
            tx_left <= tx_left - 1;
            if (tx_left == 1) tx_busy <= 1'b0;
        end
    end

    assign tx_serial = tx_busy ? tx_frame[tx_cnt / bit_clks] : 1'b1;

    // Event log, written only by this monitor.
    int         cyc = 0;
    int         acc_n = 0, we_n = 0, tmo_n = 0, rx_n = 0;
    int         acc_lane [64];
    int         acc_cyc  [64];
    int         we_cyc   [64];
    logic [7:0] we_data  [64];
    int         tmo_cyc = 0, fall_cyc = 0;
    logic       multi_ready = 1'b0, we_double = 1'b0;
    logic       prev_we = 1'b0, prev_busy = 1'b0;
    logic [9:0] rx_sr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if ($countones(o_ready) > 1) multi_ready = 1'b1;
            if (o_ready != '0 && acc_n < 64) begin
                for (int k = 0; k < N; k++)
                    if (o_ready[k]) acc_lane[acc_n] = k;
                acc_cyc[acc_n] = cyc;
                acc_n++;
            end
            if (o_tx_we && we_n < 64) begin
                if (prev_we) we_double = 1'b1;
                we_cyc[we_n]  = cyc;
                we_data[we_n] = o_tx_data;
                we_n++;
            end
            prev_we = o_tx_we;
            if (o_lock_tmo) begin
                tmo_n++;
                tmo_cyc = cyc;
            end
            if (prev_busy && !tx_busy) fall_cyc = cyc;
            prev_busy = tx_busy;
            if (tx_busy && (tx_cnt % bit_clks) == bit_clks / 2) begin
                rx_sr = {tx_serial, rx_sr[9:1]};
                rx_n++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_acc(input string tag, input int n, input int budget);
        int t = 0;
        while (acc_n < n && t < budget) begin
            tick();
            t++;
        end
        if (acc_n < n) check({tag, " accept timeout"}, acc_n, n);
    endtask

    function automatic logic queues_empty();
        logic e = 1'b1;
        for (int k = 0; k < N; k++)
            if (src_head[k] != src_tail[k]) e = 1'b0;
        return e;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while ((tx_busy || o_active || !queues_empty()) && t < budget) begin
            tick();
            t++;
        end
        if (tx_busy || o_active) check({tag, " idle timeout"}, {30'd0, tx_busy, o_active}, 0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"},    o_ready,    0);
        check({tag, " tx_we"},    o_tx_we,    0);
        check({tag, " tx_data"},  o_tx_data,  0);
        check({tag, " grant"},    o_grant,    0);
        check({tag, " active"},   o_active,   0);
        check({tag, " lock_tmo"}, o_lock_tmo, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, wb, gap, bad, t;
        logic [7:0] exp_d;

        i_rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("por");
        i_rst = 1'b0;
        tick();

        // 1: single byte on lane 0, full serial frame at 234 clk/bit.
        bit_clks = 234;
        b  = acc_n;
        wb = we_n;
        push(0, 8'h55, 1'b1);
        wait_acc("t1", b + 1, 20);
        check("t1 grant", o_grant, 4'b0001);
        wait_idle("t1", 3000);
        check("t1 lane", acc_lane[b], 0);
        check("t1 strobes", we_n - wb, 1);
        check("t1 strobe latency", we_cyc[wb] - acc_cyc[b], 1);
        check("t1 data", we_data[wb], 8'h55);
        check("t1 serial bits", rx_n, 10);
        check("t1 serial frame", rx_sr, 10'b1010101010);
        check("t1 grant idle", o_grant, 0);

        // 2: all lanes valid continuously -> strict round robin 0,1,2,3,0,1,2,3.
        do_reset();
        bit_clks = 4;
        b  = acc_n;
        wb = we_n;
        for (int k = 0; k < N; k++) begin
            push(k, 8'hA0 | 8'(k), 1'b1);
            push(k, 8'hB0 | 8'(k), 1'b1);
        end
        wait_acc("t2", b + 8, 1000);
        wait_idle("t2", 500);
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 4) ? (8'hA0 | 8'(i % 4)) : (8'hB0 | 8'(i % 4));
            check($sformatf("t2 lane[%0d]", i), acc_lane[b + i], i % 4);
            check($sformatf("t2 data[%0d]", i), we_data[wb + i], exp_d);
        end

        // 3: lane 2 message of three bytes stays contiguous, then RR resumes at lane 3.
        do_reset();
        b  = acc_n;
        wb = we_n;
        push(2, 8'hC0, 1'b0);
        wait_acc("t3", b + 1, 20);
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b1);
        push(0, 8'hD0, 1'b1);
        push(1, 8'hD1, 1'b1);
        push(3, 8'hD3, 1'b1);
        bad = 0;
        t   = 0;
        while (!o_ready[3] && t < 1000) begin
            if (o_grant != 4'b0100) bad++;
            tick();
            t++;
        end
        check("t3 grant held", bad, 0);
        wait_acc("t3", b + 6, 1000);
        wait_idle("t3", 500);
        check("t3 lane[0]", acc_lane[b + 0], 2);
        check("t3 lane[1]", acc_lane[b + 1], 2);
        check("t3 lane[2]", acc_lane[b + 2], 2);
        check("t3 lane[3]", acc_lane[b + 3], 3);
        check("t3 lane[4]", acc_lane[b + 4], 0);
        check("t3 lane[5]", acc_lane[b + 5], 1);
        check("t3 data[2]", we_data[wb + 2], 8'hC2);

        // 4: lane 1 locks then stalls; lock drops after LOCK_TMO idle ARB cycles.
        do_reset();
        b = acc_n;
        t = tmo_n;
        push(1, 8'hE1, 1'b0);
        wait_acc("t4", b + 1, 20);
        push(0, 8'hE0, 1'b1);
        tick();
        check("t4 grant locked", o_grant, 4'b0010);
        wait_acc("t4", b + 2, LOCK_TMO + 200);
        check("t4 tmo pulses", tmo_n - t, 1);
        check("t4 tmo delay", tmo_cyc - fall_cyc, LOCK_TMO + 1);
        check("t4 next lane", acc_lane[b + 1], 0);
        check("t4 next accept", acc_cyc[b + 1] - tmo_cyc, 1);
        wait_idle("t4", 500);

        // 5: busy timing at 234 clk/bit; next accept only after busy falls.
        do_reset();
        bit_clks = 234;
        b  = acc_n;
        wb = we_n;
        push(0, 8'h5A, 1'b1);
        push(0, 8'hA5, 1'b1);
        wait_acc("t5", b + 2, 5000);
        wait_idle("t5", 3000);
        gap = acc_cyc[b + 1] - we_cyc[wb];
        check("t5 accept gap", (gap >= 2341 && gap <= 2343), 1);
        check("t5 strobes", we_n - wb, 2);
        check("t5 data[1]", we_data[wb + 1], 8'hA5);

        // 6: reset while the frame is in flight clears lock and pointer.
        do_reset();
        bit_clks = 4;
        b = acc_n;
        push(2, 8'hF7, 1'b0);
        wait_acc("t6", b + 1, 20);
        t = 0;
        while (!tx_busy && t < 20) begin
            tick();
            t++;
        end
        repeat (3) tick();
        check("t6 active before reset", o_active, 1);
        i_rst = 1'b1;
        tick();
        check_reset_outputs("t6 rst");
        i_rst = 1'b0;
        wait_idle("t6", 200);
        b = acc_n;
        push(2, 8'hF2, 1'b1);
        push(3, 8'hF3, 1'b1);
        push(0, 8'hF0, 1'b1);
        wait_acc("t6", b + 3, 500);
        wait_idle("t6", 200);
        check("t6 lane[0]", acc_lane[b + 0], 0);
        check("t6 lane[1]", acc_lane[b + 1], 2);
        check("t6 lane[2]", acc_lane[b + 2], 3);

        check("ready one-hot", multi_ready, 0);
        check("tx_we single cycle", we_double, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
